// File: rtl/tx_sequencer.sv
// Transmit sequencer: frames one message as header, PAYLOAD_LEN payload bytes and a STOP byte
// over a byte-wide SPI master handshake. Optional payload escaping is enabled with TX_ESCAPE_EN.
module tx_sequencer #(
  parameter int unsigned PAYLOAD_LEN = 16,
  parameter logic [7:0]  STOP_BYTE   = 8'hCC,
  parameter logic [7:0]  HDR0_BYTE   = 8'h33,
  parameter logic [7:0]  HDR1_BYTE   = 8'h3C,
  parameter logic [7:0]  ESC_BYTE    = 8'h7D
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       transmit,
  input  logic       im_type,
  input  logic [7:0] tx_data,
  input  logic       data_valid,
  output logic       data_req,
  output logic [7:0] spi_data,
  output logic       spi_begin,
  input  logic       spi_ready,
  output logic       busy,
  output logic       done
);

  localparam int unsigned CW = (PAYLOAD_LEN > 0) ? $clog2(PAYLOAD_LEN + 1) : 1;
  localparam logic [CW-1:0] LEN = CW'(PAYLOAD_LEN);

  // An escape byte equal to the terminator would make framed payload ambiguous.
  if (ESC_BYTE == STOP_BYTE) begin : g_bad_escape
    $error("tx_sequencer: ESC_BYTE must differ from STOP_BYTE");
  end

  typedef enum logic [3:0] {
    IDLE,
    HDR,
    WAIT_H,
    FETCH,
    SEND,
    WAIT_P,
    STOP,
    WAIT_S
`ifdef TX_ESCAPE_EN
    ,
    ESC,
    WAIT_E
`endif
  } state_t;

  state_t        state, state_next;
  logic [CW-1:0] count, count_next;
  logic          frame_type, frame_type_next;
  logic [7:0]    spi_data_next;
  logic          spi_begin_next;
  logic          done_next;
`ifdef TX_ESCAPE_EN
  logic [7:0]    esc_buf, esc_buf_next;
`endif

  assign busy = (state != IDLE);

  always_comb begin
    state_next      = state;
    count_next      = count;
    frame_type_next = frame_type;
    spi_data_next   = spi_data;
    spi_begin_next  = 1'b0;
    done_next       = 1'b0;
    data_req        = 1'b0;
`ifdef TX_ESCAPE_EN
    esc_buf_next    = esc_buf;
`endif
    // spi_begin is registered, so it is still high in the first WAIT cycle;
    // a spi_ready seen alongside it belongs to no byte of ours and is dropped.
    case (state)
      IDLE: begin
        if (transmit) begin
          frame_type_next = im_type;
          count_next      = '0;
          state_next      = HDR;
        end
      end
      HDR: begin
        spi_data_next  = frame_type ? HDR1_BYTE : HDR0_BYTE;
        spi_begin_next = 1'b1;
        state_next     = WAIT_H;
      end
      WAIT_H, WAIT_P: begin
        if (spi_ready && !spi_begin) begin
          state_next = (count < LEN) ? FETCH : STOP;
        end
      end
      FETCH: begin
        data_req = data_valid;
        if (data_valid) begin
          count_next = count + CW'(1);
`ifdef TX_ESCAPE_EN
          if (tx_data == STOP_BYTE || tx_data == ESC_BYTE) begin
            esc_buf_next = tx_data;
            state_next   = ESC;
          end else begin
            spi_data_next = tx_data;
            state_next    = SEND;
          end
`else
          spi_data_next = tx_data;
          state_next    = SEND;
`endif
        end
      end
      SEND: begin
        spi_begin_next = 1'b1;
        state_next     = WAIT_P;
      end
      STOP: begin
        spi_data_next  = STOP_BYTE;
        spi_begin_next = 1'b1;
        state_next     = WAIT_S;
      end
      WAIT_S: begin
        if (spi_ready && !spi_begin) begin
          done_next  = 1'b1;
          state_next = IDLE;
        end
      end
`ifdef TX_ESCAPE_EN
      ESC: begin
        spi_data_next  = ESC_BYTE;
        spi_begin_next = 1'b1;
        state_next     = WAIT_E;
      end
      WAIT_E: begin
        if (spi_ready && !spi_begin) begin
          spi_data_next = esc_buf;
          state_next    = SEND;
        end
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      frame_type <= 1'b0;
      spi_data   <= '0;
      spi_begin  <= 1'b0;
      done       <= 1'b0;
`ifdef TX_ESCAPE_EN
      esc_buf    <= '0;
`endif
    end else begin
      state      <= state_next;
      count      <= count_next;
      frame_type <= frame_type_next;
      spi_data   <= spi_data_next;
      spi_begin  <= spi_begin_next;
      done       <= done_next;
`ifdef TX_ESCAPE_EN
      esc_buf    <= esc_buf_next;
`endif
    end
  end

endmodule

// File: tb/tb_tx_sequencer.sv
// Randomized self-checking bench for tx_sequencer: a frame-level reference model predicts the
// wire byte sequence, handshake counts and timing; a second instance covers PAYLOAD_LEN=0.
module tb_tx_sequencer;

  localparam int unsigned PL = 2;

  typedef logic [7:0] byte_q_t[$];

  logic       clk = 1'b0;
  logic       reset, transmit, im_type, data_valid, data_req;
  logic       spi_begin, spi_ready, busy, done;
  logic [7:0] tx_data, spi_data;

  logic       z_transmit, z_type, z_valid, z_req, z_begin, z_ready, z_busy, z_done;
  logic [7:0] z_tx_data, z_spi_data;

  tx_sequencer #(.PAYLOAD_LEN(PL)) dut (
    .clk(clk), .reset(reset), .transmit(transmit), .im_type(im_type),
    .tx_data(tx_data), .data_valid(data_valid), .data_req(data_req),
    .spi_data(spi_data), .spi_begin(spi_begin), .spi_ready(spi_ready),
    .busy(busy), .done(done)
  );

  tx_sequencer #(.PAYLOAD_LEN(0)) dut_z (
    .clk(clk), .reset(reset), .transmit(z_transmit), .im_type(z_type),
    .tx_data(z_tx_data), .data_valid(z_valid), .data_req(z_req),
    .spi_data(z_spi_data), .spi_begin(z_begin), .spi_ready(z_ready),
    .busy(z_busy), .done(z_done)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Frame-level reference: header, payload (escaped when enabled), terminator.
  function automatic byte_q_t expect_wire(input bit typ, input byte_q_t pl);
    byte_q_t w;
    w.push_back(typ ? 8'h3C : 8'h33);
    foreach (pl[i]) begin
`ifdef TX_ESCAPE_EN
      if (pl[i] == 8'hCC || pl[i] == 8'h7D) w.push_back(8'h7D);
`endif
      w.push_back(pl[i]);
    end
    w.push_back(8'hCC);
    return w;
  endfunction

  byte_q_t     up_q;
  byte_q_t     cap_q;
  byte_q_t     frame_pl;
  int unsigned cap_cyc[$];
  int unsigned rdy_q[$];
  int unsigned req_cyc[$];
  int unsigned viol = 0;
  bit          stall_mode = 1'b0;
  bit          glitch_en  = 1'b0;

  // Upstream buffer: presents the head of up_q, pops on data_req.
  initial begin
    data_valid = 1'b0;
    tx_data    = 8'h00;
    forever begin
      @(negedge clk);
      if (stall_mode)
        data_valid = (up_q.size() > 0) && (rdy_q.size() > 0) && (cyc > rdy_q[0] + 10);
      else
        data_valid = (up_q.size() > 0) && ($urandom_range(0, 3) != 0);
      tx_data = data_valid ? up_q[0] : 8'($urandom);
      #1;
      if (data_req) begin
        if (!data_valid) viol++;
        req_cyc.push_back(cyc);
        if (up_q.size() > 0) void'(up_q.pop_front());
      end
    end
  end

  // SPI master model: captures each byte at spi_begin, answers spi_ready after 1..4 cycles.
  initial begin
    logic [7:0]  held;
    int unsigned d;
    spi_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (spi_begin) begin
        held = spi_data;
        cap_q.push_back(spi_data);
        cap_cyc.push_back(cyc);
        spi_ready = glitch_en && ($urandom_range(0, 1) == 1);
        d = $urandom_range(1, 4);
        repeat (d) begin
          @(negedge clk);
          spi_ready = 1'b0;
          if (busy && (spi_begin || spi_data != held)) viol++;
        end
        spi_ready = 1'b1;
        rdy_q.push_back(cyc);
        @(negedge clk);
        spi_ready = 1'b0;
      end
    end
  end

  task automatic clear_frame_state();
    cap_q.delete();
    cap_cyc.delete();
    rdy_q.delete();
    req_cyc.delete();
    viol = 0;
  endtask

  task automatic run_frame(input bit typ, input bit stall, input bit glitch, input bit poke);
    byte_q_t     exp;
    int unsigned t0, done_cyc, ndone, extra_done;
    logic        busy_at_done;
    exp = expect_wire(typ, frame_pl);
    clear_frame_state();
    up_q       = frame_pl;
    stall_mode = stall;
    glitch_en  = glitch;
    done_cyc   = 0;
    ndone      = 0;
    extra_done = 0;
    busy_at_done = 1'bx;
    @(negedge clk);
    transmit = 1'b1;
    im_type  = typ;
    t0       = cyc;
    @(negedge clk);
    transmit = 1'b0;
    im_type  = 1'($urandom);
    for (int i = 0; i < 600 && ndone == 0; i++) begin
      @(negedge clk);
      transmit = poke && (cap_q.size() + 1 < exp.size()) && ($urandom_range(0, 4) == 0);
      if (done) begin
        ndone++;
        done_cyc     = cyc;
        busy_at_done = busy;
      end
    end
    transmit = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done) extra_done++;
    end
    check_eq("nbytes", cap_q.size(), exp.size());
    foreach (exp[i])
      if (i < cap_q.size()) check_eq($sformatf("byte%0d", i), cap_q[i], exp[i]);
    if (cap_cyc.size() > 0) check_eq("hdr_latency", cap_cyc[0] - t0, 2);
    check_eq("n_data_req", req_cyc.size(), frame_pl.size());
    check_eq("n_done", ndone + extra_done, 1);
    if (rdy_q.size() > 0 && ndone > 0) check_eq("done_latency", done_cyc - rdy_q[rdy_q.size()-1], 1);
    check_eq("busy_at_done", busy_at_done, 1'b0);
    check_eq("busy_after", busy, 1'b0);
    check_eq("handshake_viol", viol, 0);
    if (stall && rdy_q.size() > 0 && req_cyc.size() > 0) begin
      check_eq("stall_first_req", req_cyc[0], rdy_q[0] + 11);
      if (cap_cyc.size() > 1) check_eq("stall_resume", cap_cyc[1], req_cyc[0] + 2);
    end
    stall_mode = 1'b0;
    glitch_en  = 1'b0;
  endtask

  task automatic random_payload();
    frame_pl.delete();
    for (int i = 0; i < PL; i++) begin
      case ($urandom_range(0, 3))
        0:       frame_pl.push_back(8'hCC);
        1:       frame_pl.push_back(8'h7D);
        default: frame_pl.push_back(8'($urandom));
      endcase
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    byte_q_t     zq;
    int unsigned nzreq;
    bit          zdone_seen;
    logic        busy_pre;

    reset = 1'b1; transmit = 1'b0; im_type = 1'b0;
    z_transmit = 1'b0; z_type = 1'b0; z_valid = 1'b1; z_tx_data = 8'h55; z_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_spi_data", spi_data, 8'h00);
    check_eq("rst_spi_begin", spi_begin, 1'b0);
    check_eq("rst_data_req", data_req, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    reset = 1'b0;
    @(negedge clk);

    frame_pl = '{8'h11, 8'h22};
    run_frame(1'b0, 1'b0, 1'b0, 1'b0);

    random_payload();
    run_frame(1'b1, 1'b1, 1'b0, 1'b0);

    frame_pl = '{8'hCC, 8'h7D};
    run_frame(1'b0, 1'b0, 1'b0, 1'b0);

    random_payload();
    run_frame(1'b1, 1'b0, 1'b1, 1'b1);

    for (int f = 0; f < 20; f++) begin
      random_payload();
      run_frame(1'($urandom), 1'b0, 1'($urandom), 1'($urandom));
    end

    // Abort a frame while the first payload byte is on the wire.
    clear_frame_state();
    frame_pl = '{8'h5A, 8'hA5};
    up_q = frame_pl;
    @(negedge clk);
    transmit = 1'b1; im_type = 1'b1;
    @(negedge clk);
    transmit = 1'b0;
    for (int i = 0; i < 100 && cap_q.size() < 2; i++) @(negedge clk);
    check_eq("abort_reached", cap_q.size(), 2);
    @(negedge clk);
    #2;
    busy_pre = busy;
    reset = 1'b1;
    #1;
    check_eq("abort_busy_before", busy_pre, 1'b1);
    check_eq("abort_spi_data", spi_data, 8'h00);
    check_eq("abort_spi_begin", spi_begin, 1'b0);
    check_eq("abort_busy", busy, 1'b0);
    check_eq("abort_data_req", data_req, 1'b0);
    check_eq("abort_done", done, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    up_q.delete();
    repeat (12) @(negedge clk);
    check_eq("abort_no_stop", cap_q.size(), 2);
    random_payload();
    run_frame(1'b0, 1'b0, 1'b0, 1'b0);

    // Zero-length payload instance: header then STOP, never pulls data.
    nzreq = 0;
    zdone_seen = 1'b0;
    @(negedge clk);
    z_transmit = 1'b1;
    @(negedge clk);
    z_transmit = 1'b0;
    for (int i = 0; i < 60 && !zdone_seen; i++) begin
      @(negedge clk);
      if (z_req) nzreq++;
      if (z_done) zdone_seen = 1'b1;
      else if (z_begin) begin
        zq.push_back(z_spi_data);
        @(negedge clk);
        z_ready = 1'b1;
        @(negedge clk);
        z_ready = 1'b0;
        if (z_done) zdone_seen = 1'b1;
      end
    end
    check_eq("zero_nbytes", zq.size(), 2);
    if (zq.size() == 2) begin
      check_eq("zero_hdr", zq[0], 8'h33);
      check_eq("zero_stop", zq[1], 8'hCC);
    end
    check_eq("zero_data_req", nzreq, 0);
    check_eq("zero_done", zdone_seen, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tx_sequencer.md
Name: tx_sequencer

Overview:
Transmit-side counterpart of the receive sequencer. On a `transmit` request it drives the SPI byte interface with one framed message:
- one header byte, selected by `im_type`;
- exactly PAYLOAD_LEN payload bytes, pulled from an upstream buffer through a valid/req handshake;
- a terminating STOP byte.

It sits between the image/data buffer and the SPI master, which serialises one byte per `spi_begin` and reports completion on `spi_ready`.

Parameters:
- PAYLOAD_LEN, 16, payload bytes per frame (0 allowed).
- STOP_BYTE, 8'hCC, frame terminator.
- HDR0_BYTE, 8'h33, header sent when `im_type`=0.
- HDR1_BYTE, 8'h3C, header sent when `im_type`=1.
- ESC_BYTE, 8'h7D, escape byte (used only with TX_ESCAPE_EN).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- transmit  in  1  start request; sampled in IDLE only.
- im_type  in  1  header select; latched when `transmit` is accepted.
- tx_data  in  8  payload byte from upstream buffer.
- data_valid  in  1  `tx_data` is valid.
- data_req  out  1  byte accepted this cycle (pop); high only when `data_valid`=1 in FETCH.
- spi_data  out  8  byte presented to the SPI master; held stable until `spi_ready`.
- spi_begin  out  1  one-cycle pulse: start shifting `spi_data`.
- spi_ready  in  1  SPI master finished the current byte.
- busy  out  1  frame in progress (any state other than IDLE).
- done  out  1  one-cycle pulse after the STOP byte completes.

Behaviour:
- **Reset (asynchronous):**
  - state=IDLE, count=0;
  - spi_data=8'h00, spi_begin=0, data_req=0, busy=0, done=0, latched type=0.
  - Reset asserted mid-frame aborts the frame immediately; no STOP byte is sent.
- **States:** IDLE, HDR, WAIT_H, FETCH, SEND, WAIT_P, STOP, WAIT_S.
- **IDLE:**
  - `transmit`=1 latches `im_type`, clears count, goes to HDR.
  - `transmit` outside IDLE is ignored.
- **HDR (1 cycle):**
  - spi_data <= HDR0/HDR1 per the latched type; spi_begin=1; go to WAIT_H.
  - Latency: `spi_begin` is high 2 cycles after the `transmit` sample edge.
- **WAIT_*:**
  - spi_begin=0; wait for `spi_ready`=1.
  - `spi_ready` is ignored in the cycle `spi_begin` is high.
  - On `spi_ready`, WAIT_H/WAIT_P go to FETCH if count<PAYLOAD_LEN, else to STOP.
  - WAIT_S goes to IDLE with done=1 for one cycle.
- **FETCH:**
  - data_req = data_valid (combinational).
  - On data_valid=1: spi_data <= tx_data, count++, go to SEND.
  - With data_valid=0, FETCH stalls indefinitely; busy stays 1.
- **SEND (1 cycle):** spi_begin=1; go to WAIT_P.
- **STOP (1 cycle):** spi_data <= STOP_BYTE; spi_begin=1; go to WAIT_S.
- **Counter:** width $clog2(PAYLOAD_LEN+1); counts payload bytes accepted, never wire bytes. PAYLOAD_LEN=0 gives header then STOP.
- **Frame-level invariants:**
  - Exactly one `data_req` per payload byte.
  - `spi_begin` never asserted while waiting for `spi_ready`.
  - `spi_data` changes only in HDR/FETCH/STOP (and ESC, with the option).
- **Back-to-back frames:** `transmit` held high through `done` starts a new frame from IDLE on the next cycle (one-cycle IDLE gap minimum).

Optional Feature:
- Macro: TX_ESCAPE_EN.
- **Defined:** in FETCH, an accepted byte equal to STOP_BYTE or ESC_BYTE is buffered internally, and extra state ESC sends ESC_BYTE (spi_begin pulse, wait `spi_ready`) before SEND transmits the buffered raw byte.
  - count still increments once per payload byte.
  - The header is never escaped.
- **Undefined:** payload is sent raw; a payload byte equal to STOP_BYTE is transmitted unmodified (upstream must guarantee it is absent). The ESC state and its buffer are not synthesised.

Test Plan:
1. Reset values, then transmit=1, im_type=0, PAYLOAD_LEN=2, data 8'h11, 8'h22 always valid, spi_ready pulsed 3 cycles after each spi_begin -> wire sequence 33, 11, 22, CC; exactly 2 data_req pulses; done one cycle after the 4th spi_ready; busy low afterwards.
2. im_type=1, data_valid held low 10 cycles after the header -> header 3C; FETCH stalls, no spi_begin and data_req=0 during the stall; resumes the cycle data_valid rises.
3. PAYLOAD_LEN=0 -> wire sequence 33, CC only; zero data_req.
4. Payload 8'hCC, 8'h7D with TX_ESCAPE_EN defined -> 33, 7D, CC, 7D, 7D, CC with 2 data_req. Without the macro -> 33, CC, 7D, CC.
5. Reset asserted during WAIT_P of the first payload byte -> all outputs zero asynchronously; no STOP byte; next transmit starts a clean frame with the header.
6. transmit pulsed again mid-frame and spi_ready asserted in the same cycle as spi_begin -> both ignored; frame content and timing unchanged.
